// File: rtl/product_accumulator_if.sv
// Product hand-off bus between the upstream multiplier side (master) and the
// product accumulator (slave). ACC_W must match the accumulator it connects to.
interface product_accumulator_if #(
  parameter int ACC_W = 16
);
  logic             start;
  logic [7:0]       P;
  logic             P_valid;
  logic             P_ready;
  logic             Ack;
  logic [ACC_W-1:0] Acc;
  logic             Done;
  logic             Ovf;
  logic             Busy;

  modport master (
    output start, P, P_valid, Ack,
    input  P_ready, Acc, Done, Ovf, Busy
  );

  modport slave (
    input  start, P, P_valid, Ack,
    output P_ready, Acc, Done, Ovf, Busy
  );
endinterface

// File: rtl/product_accumulator.sv
// Sums N_TERMS 8-bit products per job into an ACC_W-bit register and holds the result until Ack.
// Saturating by default; define ACC_WRAP_EN for modulo-2^ACC_W wrap with carry-out overflow flag.
module product_accumulator #(
  parameter int ACC_W   = 16,
  parameter int N_TERMS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  product_accumulator_if.slave        bus,
  output logic [1:0]                  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(N_TERMS - 1);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic             p_ready;
  logic             done;
  logic             busy;
  logic [7:0]       cnt;
  logic [ACC_W:0]   sum;
  logic             take;

  // Handshake: a product transfers on any rising edge where P_valid and
  // P_ready are both high; P_ready is registered and high only in ACCUM, so
  // no input reaches an output combinationally.
  assign take = bus.P_valid && p_ready;
  assign sum  = {1'b0, acc} + {{(ACC_W-7){1'b0}}, bus.P};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      ovf     <= 1'b0;
      p_ready <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= ACCUM;
            acc     <= '0;
            ovf     <= 1'b0;
            cnt     <= '0;
            p_ready <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ACCUM: begin
          if (take) begin
`ifdef ACC_WRAP_EN
            acc <= sum[ACC_W-1:0];
            if (sum[ACC_W]) ovf <= 1'b1;
`else
            // Carry-out means the true sum exceeds the register; clamp at all-ones.
            if (sum[ACC_W]) begin
              acc <= '1;
              ovf <= 1'b1;
            end else begin
              acc <= sum[ACC_W-1:0];
            end
`endif
            cnt <= cnt + 8'd1;
            if (cnt == LAST_CNT) begin
              state   <= HOLD;
              p_ready <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.Ack) begin
            state <= IDLE;
            done  <= 1'b0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          p_ready <= 1'b0;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.P_ready = p_ready;
  assign bus.Acc     = acc;
  assign bus.Done    = done;
  assign bus.Ovf     = ovf;
  assign bus.Busy    = busy;
  assign dbg_state   = state;

endmodule

// File: tb/tb_product_accumulator.sv
// Drives three accumulator configurations (16b/4 terms, 8b/2 terms, 16b/1 term) with shared
// stimulus and checks each against an arithmetic job model every cycle, plus literal spot checks.
module tb_product_accumulator;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] p = 8'd0;
  logic       p_valid = 1'b0;
  logic       ack = 1'b0;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  product_accumulator_if #(.ACC_W(16)) if_a ();
  product_accumulator_if #(.ACC_W(8))  if_b ();
  product_accumulator_if #(.ACC_W(16)) if_c ();

  logic [1:0] dbg_a, dbg_b, dbg_c;

  product_accumulator #(.ACC_W(16), .N_TERMS(4)) dut_a (.clk(clk), .rst(rst), .bus(if_a), .dbg_state(dbg_a));
  product_accumulator #(.ACC_W(8),  .N_TERMS(2)) dut_b (.clk(clk), .rst(rst), .bus(if_b), .dbg_state(dbg_b));
  product_accumulator #(.ACC_W(16), .N_TERMS(1)) dut_c (.clk(clk), .rst(rst), .bus(if_c), .dbg_state(dbg_c));

  assign if_a.start = start;  assign if_a.P = p;  assign if_a.P_valid = p_valid;  assign if_a.Ack = ack;
  assign if_b.start = start;  assign if_b.P = p;  assign if_b.P_valid = p_valid;  assign if_b.Ack = ack;
  assign if_c.start = start;  assign if_c.P = p;  assign if_c.P_valid = p_valid;  assign if_c.Ack = ack;

  logic [31:0] d_acc [3];
  logic        d_ovf [3];
  logic        d_done[3];
  logic        d_rdy [3];
  logic        d_busy[3];

  assign d_acc[0] = 32'(if_a.Acc);  assign d_ovf[0] = if_a.Ovf;  assign d_done[0] = if_a.Done;
  assign d_rdy[0] = if_a.P_ready;   assign d_busy[0] = if_a.Busy;
  assign d_acc[1] = 32'(if_b.Acc);  assign d_ovf[1] = if_b.Ovf;  assign d_done[1] = if_b.Done;
  assign d_rdy[1] = if_b.P_ready;   assign d_busy[1] = if_b.Busy;
  assign d_acc[2] = 32'(if_c.Acc);  assign d_ovf[2] = if_c.Ovf;  assign d_done[2] = if_c.Done;
  assign d_rdy[2] = if_c.P_ready;   assign d_busy[2] = if_c.Busy;

  // ---------------- reference model ----------------
  // phase: 0 = waiting for start, 1 = collecting terms, 2 = result held
  int    cfg_w [3] = '{16, 8, 16};
  int    cfg_n [3] = '{4, 2, 1};
  longint m_acc [3];
  bit    m_ovf [3];
  int    m_cnt [3];
  int    m_ph  [3];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      longint maxv;
      longint s;
      maxv = (longint'(1) << cfg_w[k]) - 1;
      if (rst) begin
        m_acc[k] = 0; m_ovf[k] = 1'b0; m_cnt[k] = 0; m_ph[k] = 0;
      end else if (m_ph[k] == 0) begin
        if (start) begin
          m_acc[k] = 0; m_ovf[k] = 1'b0; m_cnt[k] = 0; m_ph[k] = 1;
        end
      end else if (m_ph[k] == 1) begin
        if (p_valid) begin
          s = m_acc[k] + longint'(p);
          if (s > maxv) begin
            m_ovf[k] = 1'b1;
`ifdef ACC_WRAP_EN
            m_acc[k] = s % (maxv + 1);
`else
            m_acc[k] = maxv;
`endif
          end else begin
            m_acc[k] = s;
          end
          m_cnt[k] = m_cnt[k] + 1;
          if (m_cnt[k] == cfg_n[k]) m_ph[k] = 2;
        end
      end else begin
        if (ack) m_ph[k] = 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("acc[%0d]", k),   longint'(d_acc[k]), m_acc[k]);
        chk($sformatf("ovf[%0d]", k),   longint'(d_ovf[k]), longint'(m_ovf[k]));
        chk($sformatf("done[%0d]", k),  longint'(d_done[k]), longint'(m_ph[k] == 2));
        chk($sformatf("ready[%0d]", k), longint'(d_rdy[k]), longint'(m_ph[k] == 1));
        chk($sformatf("busy[%0d]", k),  longint'(d_busy[k]), longint'(m_ph[k] != 0));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; p_valid = 1'b0; ack = 1'b0;
    cyc(1);
    rst = 1'b0;
  endtask

  int gap_v [7] = '{1, 0, 0, 1, 0, 1, 1};
  int gap_p [4] = '{10, 20, 30, 40};

  initial begin
    int gi;
    @(negedge clk);
    do_reset();
    chk_en = 1'b1;
    chk("reset_acc", longint'(d_acc[0]), 0);
    chk("reset_done", longint'(d_done[0]), 0);

    // Back-to-back 225s on the 16-bit / 4-term instance
    start = 1'b1; cyc(1); start = 1'b0;
    p = 8'd225; p_valid = 1'b1;
    cyc(1); chk("mac_step1", longint'(d_acc[0]), 225);
    cyc(1); chk("mac_step2", longint'(d_acc[0]), 450);
    cyc(1); chk("mac_step3", longint'(d_acc[0]), 675);
    chk("mac_done_early", longint'(d_done[0]), 0);
    cyc(1); p_valid = 1'b0;
    chk("mac_step4", longint'(d_acc[0]), 900);
    chk("mac_done", longint'(d_done[0]), 1);
    chk("mac_ovf", longint'(d_ovf[0]), 0);
    chk("mac_hold_ready", longint'(d_rdy[0]), 0);
    ack = 1'b1; cyc(1); ack = 1'b0;
    chk("mac_ack_done", longint'(d_done[0]), 0);

    // Overflow on the 8-bit / 2-term instance
    start = 1'b1; cyc(1); start = 1'b0;
    p = 8'd200; p_valid = 1'b1; cyc(1);
    p = 8'd100; cyc(1); p_valid = 1'b0;
`ifdef ACC_WRAP_EN
    chk("ovf_acc", longint'(d_acc[1]), 44);
`else
    chk("ovf_acc", longint'(d_acc[1]), 255);
`endif
    chk("ovf_flag", longint'(d_ovf[1]), 1);
    chk("ovf_done", longint'(d_done[1]), 1);
    // Ack+start together in HOLD: back to IDLE, no new job; instance A ignores both
    ack = 1'b1; start = 1'b1; cyc(1); ack = 1'b0; start = 1'b0;
    chk("ackstart_busy", longint'(d_busy[1]), 0);
    chk("accum_ignores", longint'(d_acc[0]), 300);
    chk("accum_busy", longint'(d_busy[0]), 1);
    start = 1'b1; cyc(1); start = 1'b0;
    chk("restart_acc", longint'(d_acc[1]), 0);
    chk("restart_ovf", longint'(d_ovf[1]), 0);
    do_reset();

    // Single-term instance
    start = 1'b1; cyc(1); start = 1'b0;
    p = 8'd7; p_valid = 1'b1; cyc(1); p_valid = 1'b0;
    chk("one_acc", longint'(d_acc[2]), 7);
    chk("one_done", longint'(d_done[2]), 1);
    ack = 1'b1; cyc(1); ack = 1'b0;
    chk("one_ack", longint'(d_done[2]), 0);
    do_reset();

    // Backpressure gaps on instance A
    start = 1'b1; cyc(1); start = 1'b0;
    gi = 0;
    for (int i = 0; i < 7; i++) begin
      p_valid = gap_v[i][0];
      if (gap_v[i] != 0) begin p = 8'(gap_p[gi]); gi++; end
      cyc(1);
      if (i == 5) begin
        chk("gap_partial", longint'(d_acc[0]), 60);
        chk("gap_not_done", longint'(d_done[0]), 0);
      end
    end
    p_valid = 1'b0;
    chk("gap_acc", longint'(d_acc[0]), 100);
    chk("gap_done", longint'(d_done[0]), 1);
    do_reset();

    // Reset in the middle of a job
    start = 1'b1; cyc(1); start = 1'b0;
    p = 8'd25; p_valid = 1'b1; cyc(2);
    chk("midjob_acc", longint'(d_acc[0]), 50);
    rst = 1'b1; cyc(1); rst = 1'b0;
    chk("midjob_rst_acc", longint'(d_acc[0]), 0);
    chk("midjob_rst_ready", longint'(d_rdy[0]), 0);
    cyc(3);
    chk("midjob_no_accept", longint'(d_acc[0]), 0);
    chk("midjob_idle", longint'(d_busy[0]), 0);
    p_valid = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 199) == 0);
      start   = ($urandom_range(0, 7) == 0);
      p_valid = ($urandom_range(0, 2) != 0);
      p       = 8'($urandom_range(0, 225));
      ack     = ($urandom_range(0, 3) == 0);
      cyc(1);
    end
    rst = 1'b0; start = 1'b0; p_valid = 1'b0; ack = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
Downstream consumer of the 4x4 combinational array multiplier. It takes the multiplier's 8-bit product through a valid/ready handshake. It accumulates a fixed number of products (N_TERMS) into a wider register, which gives a dot-product / MAC stage. When the last term is in, it holds the result until the consumer acknowledges it.

Parameters:
ACC_W, 16, accumulator width in bits; legal range 8..32.
N_TERMS, 4, number of products summed per job; legal range 1..255.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  one-cycle pulse that begins a job; honoured only in IDLE.
P  input  8  unsigned product from the multiplier (max 225).
P_valid  input  1  P is valid this cycle.
P_ready  output  1  block accepts P this cycle.
Ack  input  1  consumer has taken the result; honoured only in HOLD.
Acc  output  ACC_W  running / final sum; registered.
Done  output  1  result valid; high throughout HOLD.
Ovf  output  1  sticky overflow flag for the current job.
Busy  output  1  high in ACCUM and HOLD.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset (at any time, including mid-job or in HOLD): state=IDLE, Acc=0, Ovf=0, Done=0, P_ready=0, Busy=0, term counter=0. A product offered in the reset cycle is not accepted.
- FSM states: IDLE, ACCUM, HOLD. All outputs are decoded from registered state, so there is no combinational path from input to output.
- IDLE:
  - P_ready=0, Done=0, Busy=0.
  - Acc and Ovf keep the previous job's values.
  - start=1: next cycle Acc=0, Ovf=0, cnt=0, state=ACCUM.
- ACCUM:
  - P_ready=1, Busy=1.
  - A transfer happens when P_valid&P_ready. On a transfer, Acc <= Acc + zero-extended P (overflow rules below), and cnt <= cnt+1.
  - Acc shows the new sum the cycle after the transfer.
  - If the transfer is the N_TERMS-th one, state goes to HOLD in the same edge.
  - P_valid=0: Acc and cnt are held. Gaps of any length are legal.
  - start in ACCUM is ignored.
- HOLD:
  - Done=1, P_ready=0, Busy=1. Acc and Ovf are frozen.
  - Ack=1: next cycle state=IDLE, Done=0.
  - start in HOLD is ignored, including when it arrives in the same cycle as Ack. A new start is needed in IDLE.
- Latency: Done rises exactly 1 cycle after the final accepted product. A back-to-back job takes N_TERMS+3 cycles (start through Ack through the next start).
- Overflow (default build, saturating):
  - If Acc+P > 2^ACC_W-1, Acc <= 2^ACC_W-1 and Ovf <= 1.
  - Ovf stays set until the next start or rst.
  - Once Acc is saturated, it stays saturated.
- N_TERMS=1: one transfer moves the block directly to HOLD.

Optional Feature:
ACC_WRAP_EN
- Defined: the accumulator wraps modulo 2^ACC_W. Ovf is set sticky by the carry-out of any addition. There is no saturation.
- Undefined: saturating behaviour as described above.
- All other timing is identical in both builds.

Test Plan:
- ACC_W=16, N_TERMS=4: start; feed P=225 four times back-to-back -> Acc steps 225, 450, 675, 900; Done=1 the cycle after the 4th transfer; Ovf=0; P_ready=0 in HOLD.
- Backpressure gaps: P_valid pattern 1,0,0,1,0,1,1 with P=10,20,30,40 -> Acc=100 only after the 4th transfer; Acc held during gaps; Done timing is relative to the last transfer.
- ACC_W=8, N_TERMS=2, saturating build: P=200 then 100 -> Acc=255, Ovf=1. With ACC_WRAP_EN defined -> Acc=44, Ovf=1.
- Reset mid-job: after 2 of 4 transfers (Acc=50), assert rst for 1 cycle -> next cycle Acc=0, state IDLE, P_ready=0. A P_valid held high afterwards is not accepted without a start.
- Handshake corners: start during ACCUM ignored (cnt unchanged). Ack and start together in HOLD -> IDLE, no new job. A later start clears Acc and Ovf. Ack while in ACCUM has no effect.
- N_TERMS=1: start, then one transfer P=7 -> Acc=7, Done=1 the next cycle; Ack -> Done=0 one cycle later.
